// File: rtl/fifo_stream_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_stream_arbiter
//
// Round-robin, burst-limited arbiter merging N show-ahead 32-bit word sources
// into one registered output word with a pop handshake (feeds the readout
// BRAM FIFO). Each grant takes up to BURST_MAX consecutive words from one
// source, then re-arbitrates starting after the last winner.
//
// Ports:
//   CLK        sole clock, rising edge
//   RESETB     asynchronous active-low reset
//   ENABLE     per-source enable mask
//   IN_EMPTY   per-source empty flag; IN_DATA slice valid while low
//   IN_DATA    source words, source i at [32*i+31:32*i]
//   IN_READ    per-source pop strobe (only combinational output)
//   OUT_READ   downstream pop, honoured only while OUT_EMPTY=0
//   OUT_EMPTY  output register holds no word
//   OUT_DATA   output word
//   OUT_SRC    index of the source that produced OUT_DATA
//   GRANT      one-hot current grant, zero when idle
//   WORD_CNT   total words forwarded (wraps)
// ----------------------------------------------------------------------------
module fifo_stream_arbiter #(
    parameter int N         = 4,
    parameter int BURST_MAX = 16,
    parameter int SW        = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RESETB,
    input  logic [N-1:0]    ENABLE,
    input  logic [N-1:0]    IN_EMPTY,
    input  logic [32*N-1:0] IN_DATA,
    output logic [N-1:0]    IN_READ,
    input  logic            OUT_READ,
    output logic            OUT_EMPTY,
    output logic [31:0]     OUT_DATA,
    output logic [SW-1:0]   OUT_SRC,
    output logic [N-1:0]    GRANT,
    output logic [31:0]     WORD_CNT
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    state_t        state;
    logic [SW-1:0] gidx;       // index of the granted source
    logic [SW-1:0] last;       // most recent winner, round-robin pointer
    logic [7:0]    burst_cnt;  // words taken in the current burst

    logic          accept;
    logic          rd;
    logic          burst_end;
    logic [N-1:0]  req;
    logic          found;
    logic [SW-1:0] sel;
    logic [SW-1:0] cand;

    // The output register can take a word when it is empty or being popped
    // in this same cycle, which gives one word per cycle sustained.
    assign accept = OUT_EMPTY | OUT_READ;
    assign req    = ENABLE & ~IN_EMPTY;
    assign rd     = (state == BURST) && !IN_EMPTY[gidx] && ENABLE[gidx] && accept;

    // A stalled burst (accept=0) on an empty source holds its grant; only a
    // disable or a completed/drained burst releases it.
    assign burst_end = (rd && (burst_cnt == BURST_LAST))
                     || (IN_EMPTY[gidx] && accept)
                     || !ENABLE[gidx];

    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch for the untaken path.
    always_comb begin
        IN_READ = '0;
        if (rd) begin
            IN_READ[gidx] = 1'b1;
        end
    end

    // Search last+1, last+2, ..., last (mod N); N is a power of two so the
    // SW-bit addition wraps naturally.
    always_comb begin
        found = 1'b0;
        sel   = last;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = last + SW'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state     <= IDLE;
            GRANT     <= '0;
            gidx      <= '0;
            last      <= SW'(N - 1);  // source 0 wins the first arbitration
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BURST;
                        GRANT     <= N'(1) << sel;
                        gidx      <= sel;
                        last      <= sel;
                        burst_cnt <= '0;
                    end
                end
                BURST: begin
                    if (rd) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                    if (burst_end) begin
                        state <= IDLE;
                        GRANT <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    GRANT <= '0;
                end
            endcase
        end
    end

    // Output register and word counter. A word held at reset is discarded.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            OUT_EMPTY <= 1'b1;
            OUT_DATA  <= '0;
            OUT_SRC   <= '0;
            WORD_CNT  <= '0;
        end else begin
            if (rd) begin
                OUT_DATA  <= IN_DATA[32*int'(gidx) +: 32];
                OUT_SRC   <= gidx;
                OUT_EMPTY <= 1'b0;
                WORD_CNT  <= WORD_CNT + 32'd1;
            end else if (OUT_READ) begin
                // Popping an already-empty register leaves it empty.
                OUT_EMPTY <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream_arbiter
//
// Directed bench for fifo_stream_arbiter (N=4, BURST_MAX=4). Each source is a
// show-ahead FIFO model whose word encodes {4'hA, source, 8'h00, index}, so
// every popped word identifies its origin and position.
// ----------------------------------------------------------------------------
module tb_fifo_stream_arbiter;

    localparam int N  = 4;
    localparam int BM = 4;
    localparam int SW = 2;

    logic            CLK = 1'b0;
    logic            RESETB;
    logic [N-1:0]    ENABLE;
    logic [N-1:0]    IN_EMPTY;
    logic [32*N-1:0] IN_DATA;
    logic [N-1:0]    IN_READ;
    logic            OUT_READ;
    logic            OUT_EMPTY;
    logic [31:0]     OUT_DATA;
    logic [SW-1:0]   OUT_SRC;
    logic [N-1:0]    GRANT;
    logic [31:0]     WORD_CNT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fifo_stream_arbiter #(
        .N         (N),
        .BURST_MAX (BM),
        .SW        (SW)
    ) dut (
        .CLK       (CLK),
        .RESETB    (RESETB),
        .ENABLE    (ENABLE),
        .IN_EMPTY  (IN_EMPTY),
        .IN_DATA   (IN_DATA),
        .IN_READ   (IN_READ),
        .OUT_READ  (OUT_READ),
        .OUT_EMPTY (OUT_EMPTY),
        .OUT_DATA  (OUT_DATA),
        .OUT_SRC   (OUT_SRC),
        .GRANT     (GRANT),
        .WORD_CNT  (WORD_CNT)
    );

    // ---------------- source models ----------------
    int total  [N];  // words ever loaded into source i
    int popped [N];  // words ever popped from source i

    function automatic logic [31:0] word(input int s, input int idx);
        return {4'hA, 4'(s), 8'h00, 16'(idx)};
    endfunction

    always_comb begin
        IN_EMPTY = '0;
        IN_DATA  = '0;
        for (int i = 0; i < N; i++) begin
            IN_EMPTY[i]         = (popped[i] == total[i]);
            IN_DATA[32*i +: 32] = word(i, popped[i]);
        end
    end

    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (IN_READ[i] && (popped[i] < total[i])) begin
                popped[i] <= popped[i] + 1;
            end
        end
    end

    // ---------------- per-cycle observation ----------------
    logic [N-1:0]  s_grant;
    logic [N-1:0]  s_rd;
    logic [N-1:0]  grant_log [$];
    logic [N-1:0]  rd_log    [$];
    logic          oe_log    [$];
    logic [SW-1:0] pop_src   [$];
    logic [31:0]   pop_data  [$];
    int            viol = 0;  // illegal IN_READ patterns seen

    task automatic clear_logs();
        grant_log.delete();
        rd_log.delete();
        oe_log.delete();
        pop_src.delete();
        pop_data.delete();
    endtask

    // Called at a falling edge: samples the cycle, then waits for the next
    // falling edge (one rising edge passes in between).
    task automatic tick();
        #1;
        s_grant = GRANT;
        s_rd    = IN_READ;
        grant_log.push_back(GRANT);
        rd_log.push_back(IN_READ);
        oe_log.push_back(OUT_EMPTY);
        if (OUT_READ && !OUT_EMPTY) begin
            pop_src.push_back(OUT_SRC);
            pop_data.push_back(OUT_DATA);
        end
        if (((IN_READ & (IN_EMPTY | ~ENABLE)) != '0) || ($countones(IN_READ) > 1)) begin
            viol++;
        end
        @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESETB   = 1'b0;
        ENABLE   = '1;
        OUT_READ = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        checks++; if (OUT_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_out_empty: got %0b want 1", OUT_EMPTY); end
        checks++; if (GRANT !== 4'h0) begin errors++; $display("FAIL reset_grant: got %h want 0", GRANT); end
        checks++; if (IN_READ !== 4'h0) begin errors++; $display("FAIL reset_in_read: got %h want 0", IN_READ); end
        checks++; if (WORD_CNT !== 32'h0) begin errors++; $display("FAIL reset_word_cnt: got %h want 0", WORD_CNT); end
        checks++; if (OUT_DATA !== 32'h0 || OUT_SRC !== 2'd0) begin
            errors++; $display("FAIL reset_out_data: got %h/%0d want 0/0", OUT_DATA, OUT_SRC);
        end
        @(negedge CLK);
        RESETB = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        int j;
        clear_logs();
        for (int s = 0; s < N; s++) total[s] += 3;
        OUT_READ = 1'b1;
        repeat (24) tick();
        // GRANT: idle, then per source 4 cycles (3 reads + drained cycle) and one idle
        for (int k = 0; k < 22; k++) begin
            exp_g = '0;
            if (k > 0) begin
                j = k - 1;
                if ((j / 5 < 4) && (j % 5 < 4)) exp_g = 4'(1 << (j / 5));
            end
            checks++; if (grant_log[k] !== exp_g) begin
                errors++; $display("FAIL rr_grant[%0d]: got %h want %h", k, grant_log[k], exp_g);
            end
        end
        checks++; if (oe_log[1] !== 1'b1 || oe_log[2] !== 1'b0) begin
            errors++; $display("FAIL rr_latency: out_empty t+1=%0b t+2=%0b want 1,0", oe_log[1], oe_log[2]);
        end
        checks++; if (pop_data.size() != 12) begin
            errors++; $display("FAIL rr_pop_count: got %0d want 12", pop_data.size());
        end
        for (int i = 0; i < 12 && i < pop_data.size(); i++) begin
            checks++; if (pop_src[i] !== 2'(i / 3) || pop_data[i] !== word(i / 3, i % 3)) begin
                errors++; $display("FAIL rr_pop[%0d]: got src %0d data %h want src %0d data %h",
                                   i, pop_src[i], pop_data[i], i / 3, word(i / 3, i % 3));
            end
        end
        checks++; if (WORD_CNT !== 32'd12) begin errors++; $display("FAIL rr_word_cnt: got %0d want 12", WORD_CNT); end
    endtask

    task automatic test_burst_limit();
        int bl_src [6] = '{0, 2, 0, 2, 0, 2};
        int bl_len [6] = '{4, 4, 4, 4, 2, 2};
        int nxt    [N];
        int exp_s  [$];
        int exp_i  [$];
        int rd_at  [$];
        int bad;
        clear_logs();
        total[0] += 10;
        total[2] += 10;
        OUT_READ = 1'b1;
        repeat (45) tick();
        nxt = '{3, 3, 3, 3};
        for (int b = 0; b < 6; b++) begin
            for (int w = 0; w < bl_len[b]; w++) begin
                exp_s.push_back(bl_src[b]);
                exp_i.push_back(nxt[bl_src[b]]);
                nxt[bl_src[b]]++;
            end
        end
        checks++; if (pop_data.size() != 20) begin
            errors++; $display("FAIL bl_pop_count: got %0d want 20", pop_data.size());
        end
        for (int i = 0; i < 20 && i < pop_data.size(); i++) begin
            checks++; if (pop_src[i] !== 2'(exp_s[i]) || pop_data[i] !== word(exp_s[i], exp_i[i])) begin
                errors++; $display("FAIL bl_pop[%0d]: got src %0d data %h want src %0d data %h",
                                   i, pop_src[i], pop_data[i], exp_s[i], word(exp_s[i], exp_i[i]));
            end
        end
        bad = 0;
        for (int k = 0; k < rd_log.size(); k++) begin
            if (rd_log[k][1] || rd_log[k][3]) bad++;
            if (rd_log[k] != '0) rd_at.push_back(k);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bl_idle_sources_read: got %0d reads want 0", bad); end
        checks++; if (rd_at.size() != 20 || (rd_at[4] - rd_at[3]) != 2) begin
            errors++; $display("FAIL bl_gap: got %0d reads, gap %0d want 20 reads, gap 2",
                               rd_at.size(), (rd_at.size() > 4) ? rd_at[4] - rd_at[3] : -1);
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL bl_read_legal: got %0d illegal reads want 0", viol); end
    endtask

    task automatic test_stall();
        int nrd;
        int bad;
        clear_logs();
        OUT_READ = 1'b0;
        total[1] += 6;
        repeat (22) tick();
        nrd = 0;
        bad = 0;
        for (int k = 0; k < 22; k++) begin
            nrd += $countones(rd_log[k]);
            if (k >= 1 && grant_log[k] !== 4'b0010) bad++;
        end
        checks++; if (nrd != 1) begin errors++; $display("FAIL stall_reads: got %0d want 1", nrd); end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_grant_held: got %0d changed cycles want 0", bad); end
        checks++; if (OUT_EMPTY !== 1'b0) begin errors++; $display("FAIL stall_out_full: got %0b want 0", OUT_EMPTY); end
        clear_logs();
        OUT_READ = 1'b1;
        repeat (20) tick();
        checks++; if (pop_data.size() != 6) begin
            errors++; $display("FAIL stall_pop_count: got %0d want 6", pop_data.size());
        end
        for (int i = 0; i < 6 && i < pop_data.size(); i++) begin
            checks++; if (pop_src[i] !== 2'd1 || pop_data[i] !== word(1, 3 + i)) begin
                errors++; $display("FAIL stall_pop[%0d]: got src %0d data %h want src 1 data %h",
                                   i, pop_src[i], pop_data[i], word(1, 3 + i));
            end
        end
    endtask

    task automatic test_enable_drop();
        logic found;
        int   exp_s [6] = '{1, 1, 3, 3, 3, 3};
        int   exp_i [6] = '{9, 10, 3, 4, 5, 6};
        clear_logs();
        OUT_READ = 1'b1;
        total[1] += 8;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            tick();
            found = (s_grant == 4'b0010);
        end
        checks++; if (!found) begin errors++; $display("FAIL en_grant1: got %h want 0010 within 6 cycles", s_grant); end
        tick();                          // second read of the burst
        ENABLE[1] = 1'b0;
        total[3] += 4;
        tick();
        checks++; if (s_rd[1] !== 1'b0 || s_grant !== 4'b0010) begin
            errors++; $display("FAIL en_drop_cycle: got in_read %h grant %h want 0/0010", s_rd, s_grant);
        end
        tick();
        checks++; if (s_grant !== 4'b0000) begin errors++; $display("FAIL en_gap: got grant %h want 0", s_grant); end
        tick();
        checks++; if (s_grant !== 4'b1000) begin errors++; $display("FAIL en_next_grant: got %h want 1000", s_grant); end
        repeat (10) tick();
        checks++; if (pop_data.size() != 6) begin
            errors++; $display("FAIL en_pop_count: got %0d want 6", pop_data.size());
        end
        for (int i = 0; i < 6 && i < pop_data.size(); i++) begin
            checks++; if (pop_src[i] !== 2'(exp_s[i]) || pop_data[i] !== word(exp_s[i], exp_i[i])) begin
                errors++; $display("FAIL en_pop[%0d]: got src %0d data %h want src %0d data %h",
                                   i, pop_src[i], pop_data[i], exp_s[i], word(exp_s[i], exp_i[i]));
            end
        end
    endtask

    task automatic test_async_reset();
        logic found;
        int   exp_s [7] = '{0, 0, 1, 1, 1, 1, 1};
        int   exp_i [7] = '{13, 14, 12, 13, 14, 15, 16};
        clear_logs();
        OUT_READ = 1'b0;
        ENABLE   = '1;
        repeat (3) tick();
        checks++; if (OUT_EMPTY !== 1'b0 || GRANT !== 4'b0010) begin
            errors++; $display("FAIL ar_precondition: got out_empty %0b grant %h want 0/0010", OUT_EMPTY, GRANT);
        end
        RESETB = 1'b0;
        total[0] += 2;
        #1;
        checks++; if (OUT_EMPTY !== 1'b1 || GRANT !== 4'h0 || IN_READ !== 4'h0 || WORD_CNT !== 32'h0) begin
            errors++; $display("FAIL ar_immediate: got out_empty %0b grant %h in_read %h word_cnt %h want 1/0/0/0",
                               OUT_EMPTY, GRANT, IN_READ, WORD_CNT);
        end
        @(negedge CLK);
        RESETB   = 1'b1;
        OUT_READ = 1'b1;
        clear_logs();
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            tick();
            found = (s_grant != '0);
        end
        checks++; if (s_grant !== 4'b0001) begin errors++; $display("FAIL ar_first_grant: got %h want 0001", s_grant); end
        repeat (20) tick();
        checks++; if (pop_data.size() != 7) begin
            errors++; $display("FAIL ar_pop_count: got %0d want 7", pop_data.size());
        end
        for (int i = 0; i < 7 && i < pop_data.size(); i++) begin
            checks++; if (pop_src[i] !== 2'(exp_s[i]) || pop_data[i] !== word(exp_s[i], exp_i[i])) begin
                errors++; $display("FAIL ar_pop[%0d]: got src %0d data %h want src %0d data %h",
                                   i, pop_src[i], pop_data[i], exp_s[i], word(exp_s[i], exp_i[i]));
            end
        end
        checks++; if (WORD_CNT !== 32'd7) begin errors++; $display("FAIL ar_word_cnt: got %0d want 7", WORD_CNT); end
    endtask

    task automatic test_word_cnt_wrap();
        force dut.WORD_CNT = 32'hFFFF_FFFE;
        #1;
        release dut.WORD_CNT;
        #1;
        checks++; if (WORD_CNT !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL wrap_preload: got %h want fffffffe", WORD_CNT);
        end
        @(negedge CLK);
        clear_logs();
        OUT_READ = 1'b1;
        total[2] += 3;
        repeat (12) tick();
        checks++; if (WORD_CNT !== 32'h0000_0001) begin
            errors++; $display("FAIL wrap_word_cnt: got %h want 00000001", WORD_CNT);
        end
        checks++; if (pop_data.size() != 3 || pop_data[2] !== word(2, 15)) begin
            errors++; $display("FAIL wrap_pops: got %0d pops, last %h want 3, %h",
                               pop_data.size(), (pop_data.size() > 2) ? pop_data[2] : 32'h0, word(2, 15));
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL read_legal: got %0d illegal reads want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_limit();
        test_stall();
        test_enable_drop();
        test_async_reset();
        test_word_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
